apb_master_arbiter: RTL
=======================

# apb_master_arbiter

Shares one APB master port among NREQ local requesters. It arbitrates round-robin, runs the APB IDLE/SETUP/ACCESS sequence for the winner, and returns read data or a timeout error to that requester. It sits between the block-level register clients and the APB peripheral bus, where the standalone bridge would otherwise serve a single client.

## Interface
- WIDTH, 16, address/data width
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 8, maximum ACCESS cycles waiting for pready; 0 disables the timeout
- pclk  in  1  clock
- preset  in  1  reset; one clock, synchronous, active-high
- req_valid  in  NREQ  request pending, one bit per requester; held until req_ready
- req_write  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*WIDTH  requester i at [i*WIDTH +: WIDTH]
- req_wdata  in  NREQ*WIDTH  same packing as req_addr
- req_ready  out  NREQ  one-hot, one-cycle request-accepted pulse
- rsp_valid  out  NREQ  one-hot, one-cycle completion pulse
- rsp_rdata  out  WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  timeout abort, qualified by rsp_valid
- pselect, penable, pwrite  out  1  APB control
- paddr, pwdata  out  WIDTH  APB address and write data
- pready  in  1  peripheral ready
- prdata  in  WIDTH  peripheral read data

## Operation
- FSM states are one-hot: IDLE=3'b001, SETUP=3'b010, ACCESS=3'b100. Illegal encodings go to IDLE.
- Outputs are decoded from registers only, with no input-to-output combinational path:
  - pselect = (SETUP or ACCESS)
  - penable = ACCESS
- Grant event: occurs at an edge where the FSM is in IDLE, or in ACCESS completing, and any req_valid is high.
  - The winner is the first set bit searching from last_grant+1, wrapping modulo NREQ.
  - At that edge: last_grant←winner; paddr, pwdata, pwrite load from the winner's slice; state→SETUP.
- req_ready[winner] is high during the SETUP cycle only. The requester drops or changes req_valid on the following edge.
- paddr, pwdata and pwrite hold stable through SETUP and ACCESS, and retain their last values in IDLE.
- SETUP always goes to ACCESS after one cycle.
- ACCESS:
  - A wait counter increments each ACCESS cycle with pready low.
  - Completion on pready=1: rsp_rdata←prdata for a read, 0 for a write; rsp_err←0.
  - Abort when pready is low in the TIMEOUT-th ACCESS cycle: rsp_rdata←0, rsp_err←1, with APB strobes dropped exactly as on a normal completion.
  - On completion or abort, rsp_valid[winner] pulses in the next cycle. The FSM then takes a new grant (→SETUP) if any req_valid is high, otherwise goes to IDLE.
- Back-to-back transfers never pass through IDLE. pselect stays high and penable drops for the SETUP cycle.
- Reset values:
  - state=IDLE; last_grant=NREQ-1 (requester 0 has first priority).
  - All outputs 0, including paddr and pwdata; wait counter 0.
- Reset asserted mid-transfer: the next edge forces IDLE, pselect=penable=0, and req_ready and rsp_valid to 0. No response is ever issued for the aborted transfer.
- A requester may raise req_valid in the same cycle its rsp_valid is high. That request is considered at the next grant event.
- The wait counter width is clog2(TIMEOUT+1), with a minimum of 1. The counter clears on every grant.

## Timing
- A zero-wait transfer takes 2 cycles on the bus: SETUP, then ACCESS.
- Latency from req_valid sampled in IDLE to rsp_valid is 3 cycles with zero waits, plus 1 per wait state.
- Sustained back-to-back throughput is one transfer per 2 cycles.
- req_ready coincides with SETUP. rsp_valid coincides with the next SETUP when back-to-back, or with IDLE otherwise.
- An abort occurs after exactly TIMEOUT ACCESS cycles. rsp_valid follows one cycle later.

## Structure
- Package apb_ctrl_pkg holds:
  - the IDLE/SETUP/ACCESS state localparams;
  - a clog2-based width helper for the wait counter.
- Sub-module rr_arbiter (NREQ) holds the combinational round-robin pick from req_valid and last_grant, and outputs a one-hot grant plus an index. The parent owns the last_grant register.
- The top level contains the FSM, the APB address/data/control registers, the wait counter and the response registers.

## Test plan
Parameters: WIDTH=16, NREQ=4, TIMEOUT=8 unless stated.
- Single read: requester 2 reads 0x0040, prdata=0xBEEF with pready high in the first ACCESS cycle → SETUP/ACCESS one cycle each; rsp_valid=4'b0100 with rsp_rdata=0xBEEF and rsp_err=0, 3 cycles after the request is sampled.
- Write with 3 wait states: requester 0 writes 0x1234 to 0x0010 → paddr and pwdata stable for 5 bus cycles (SETUP + 4 ACCESS); rsp_valid=4'b0001 with rsp_rdata=0.
- Round-robin under contention: all 4 requesters hold valid from reset → grant order 0,1,2,3,0; back-to-back transfers with no IDLE; one rsp per 2 cycles.
- Timeout: pready held low → abort after 8 ACCESS cycles; rsp_err=1 and rsp_rdata=0; next request proceeds normally. Repeat with TIMEOUT=0 and 20 wait states → no abort.
- Reset mid-ACCESS: preset for one cycle during a wait state → pselect=penable=0 on the next edge; no rsp_valid; requester 0 wins first after reset.
- Re-request on response: requester 1 reasserts valid in its rsp_valid cycle while requester 3 is also valid → requester 3 wins next, then requester 1.

Source files
------------

// File: rtl/apb_ctrl_pkg.sv
// Shared types and helpers for the multi-requester APB master.
// State encodings are one-hot; the wait counter width comes from TIMEOUT.
package apb_ctrl_pkg;

    localparam logic [2:0] IDLE_ENC   = 3'b001;
    localparam logic [2:0] SETUP_ENC  = 3'b010;
    localparam logic [2:0] ACCESS_ENC = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE   = IDLE_ENC,
        ST_SETUP  = SETUP_ENC,
        ST_ACCESS = ACCESS_ENC
    } state_t;

    function automatic int wait_cnt_w(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester-side handshake and APB master bus bundled for the arbiter.
// master = the arbiter; slave = requesters plus peripheral side.
interface apb_master_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_write;
    logic [NREQ*WIDTH-1:0] req_addr;
    logic [NREQ*WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_rdata;
    logic                  rsp_err;
    logic                  pselect;
    logic                  penable;
    logic                  pwrite;
    logic [WIDTH-1:0]      paddr;
    logic [WIDTH-1:0]      pwdata;
    logic                  pready;
    logic [WIDTH-1:0]      prdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  pready, prdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output pselect, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output pready, prdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  pselect, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master_arbiter_rr.sv
// Combinational round-robin pick: first set request after last grant.
// Returns a one-hot grant, its index and whether anything was pending.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_last,
    output logic [NREQ-1:0]         o_gnt,
    output logic [$clog2(NREQ)-1:0] o_idx,
    output logic                    o_any
);
    localparam int IW = $clog2(NREQ);

    int w_pos;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_pos = (int'(i_last) + k) % NREQ;
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by NREQ requesters with round-robin arbitration.
// Runs SETUP/ACCESS per grant and returns data or a timeout error.
import apb_ctrl_pkg::*;

module apb_master_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                 i_pclk,
    input  logic                 i_preset,
    apb_master_arbiter_if.master bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = wait_cnt_w(TIMEOUT);
    localparam logic [CW-1:0] W_LAST   = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    state_t           r_state;
    state_t           w_state_nx;
    logic [IW-1:0]    r_last;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_rsp_valid;
    logic [WIDTH-1:0] r_paddr;
    logic [WIDTH-1:0] r_pwdata;
    logic [WIDTH-1:0] r_rdata;
    logic             r_pwrite;
    logic             r_err;
    logic [CW-1:0]    r_wait;

    logic [NREQ-1:0]  w_gnt;
    logic [IW-1:0]    w_idx;
    logic             w_any;
    logic             w_access;
    logic             w_timeout;
    logic             w_done;
    logic             w_grant;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .i_req  (bus.req_valid),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign w_access  = (r_state == ST_ACCESS);
    // Abort in the TIMEOUT-th ACCESS cycle: r_wait counts earlier low cycles.
    assign w_timeout = (TIMEOUT != 0) && !bus.pready && (r_wait == W_LAST);
    assign w_done    = w_access && (bus.pready || w_timeout);
    assign w_grant   = w_any && ((r_state == ST_IDLE) || w_done);

    always_comb begin
        w_state_nx = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_state_nx = w_grant ? ST_SETUP : ST_IDLE;
            ST_SETUP:  w_state_nx = ST_ACCESS;
            ST_ACCESS: begin
                if (!w_done)      w_state_nx = ST_ACCESS;
                else if (w_grant) w_state_nx = ST_SETUP;
                else              w_state_nx = ST_IDLE;
            end
            default:   w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_pclk) begin
        if (i_preset) r_state <= ST_IDLE;
        else          r_state <= w_state_nx;
    end

    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_last      <= LAST_RST;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_wait      <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (w_grant) begin
                r_last   <= w_idx;
                r_gnt    <= w_gnt;
                r_paddr  <= bus.req_addr[w_idx*WIDTH +: WIDTH];
                r_pwdata <= bus.req_wdata[w_idx*WIDTH +: WIDTH];
                r_pwrite <= bus.req_write[w_idx];
                r_wait   <= '0;
            end else if (w_access && !bus.pready) begin
                r_wait <= r_wait + 1'b1;
            end
            // r_gnt/r_pwrite still describe the finishing transfer here.
            if (w_done) begin
                r_rsp_valid <= r_gnt;
                r_err       <= !bus.pready;
                r_rdata     <= (bus.pready && !r_pwrite) ? bus.prdata : '0;
            end
        end
    end

    assign bus.req_ready = (r_state == ST_SETUP) ? r_gnt : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign bus.pselect   = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign bus.penable   = (r_state == ST_ACCESS);
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;

endmodule
